// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU pipeline stage registers.
// Holds the stage occupancy enum, the default payload width and the
// default bubble (NOP) payload used on reset and flush.
package cpu_types_pkg;

  // Widest stage bundle; individual stages override DATA_W downward.
  localparam int STAGE_DATA_W = 128;

  // Bubble payload: all-zero decodes as a NOP in every stage bundle.
  localparam logic [STAGE_DATA_W-1:0] NOP_DEFAULT = '0;

  // Encoded so the state value is the entry count directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // Entries held for a given state.
  function automatic logic [1:0] state_occ(input stage_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, freeze and flush.
// Build option: define PIPE_SKID_EN for a two-entry skid buffer whose
// in_ready depends only on registered state; without it the stage holds a
// single entry and in_ready passes out_ready straight through.
module pipe_stage_reg
  import cpu_types_pkg::*;
#(
  parameter int                DATA_W  = STAGE_DATA_W,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_DEFAULT)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  stage_state_t      state;
  logic [DATA_W-1:0] head;
`ifdef PIPE_SKID_EN
  logic [DATA_W-1:0] skid;
`endif

  logic accept;
  logic retire;

  // Outputs come straight from registered state: no X after reset, and
  // out_data shows the bubble whenever nothing is held.
  assign out_valid = (state != EMPTY);
  assign out_data  = head;
  assign occ       = state_occ(state);

`ifdef PIPE_SKID_EN
  // Room exists unless both slots are full; out_ready never reaches here.
  assign in_ready = en && (state != TWO);
`else
  // Single slot: only free if empty or the head leaves this same cycle.
  assign in_ready = en && (!out_valid || out_ready);
`endif

  // Handshakes both qualified by en, so a frozen stage neither takes nor gives.
  assign accept = en && in_valid && in_ready;
  assign retire = en && out_valid && out_ready;

  // Occupancy FSM and payload slots; flush wins over any handshake and
  // ignores en so a redirect always clears the stage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= EMPTY;
      head  <= NOP_VAL;
`ifdef PIPE_SKID_EN
      skid  <= NOP_VAL;
`endif
    end else if (flush) begin
      state <= EMPTY;
      head  <= NOP_VAL;
`ifdef PIPE_SKID_EN
      skid  <= NOP_VAL;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head  <= in_data;
            state <= ONE;
          end
        end
        ONE: begin
          if (accept && retire) begin
            head <= in_data;
          end else if (retire) begin
            head  <= NOP_VAL;
            state <= EMPTY;
          end
`ifdef PIPE_SKID_EN
          else if (accept) begin
            // Head is stalled downstream: park the new entry behind it.
            skid  <= in_data;
            state <= TWO;
          end
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: begin
          // in_ready is low here, so only a retire can move things.
          if (retire) begin
            head  <= skid;
            skid  <= NOP_VAL;
            state <= ONE;
          end
        end
`endif
        default: begin
          // Unreachable encoding for this build: fall back to a bubble.
          state <= EMPTY;
          head  <= NOP_VAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg (default build and PIPE_SKID_EN build).
module tb_pipe_stage_reg;
  import cpu_types_pkg::*;

  localparam int W = 128;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         en, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occ;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(W)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occ(occ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] o, input logic [W-1:0] d);
    chk({tag, ".occ"}, W'(occ), W'(o));
    chk({tag, ".valid"}, W'(out_valid), W'(o != 2'd0));
    chk({tag, ".data"}, out_data, d);
  endtask

  initial begin
    nRST = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_data = {16{8'hA5}};

    // Reset held with a valid payload pending.
    step(); step();
    chk_state("reset", 2'd0, '0);
    nRST = 1'b1;

    // Stream 1,2,3 with downstream always ready.
    in_data = 1; step(); chk_state("stream1", 2'd1, 1);
    in_data = 2; step(); chk_state("stream2", 2'd1, 2);
    in_data = 3; step(); chk_state("stream3", 2'd1, 3);
    in_valid = 1'b0; step(); chk_state("drain", 2'd0, '0);

    // Freeze with en low: nothing moves, in_ready forced low.
    in_valid = 1'b1; in_data = 'h44; step(); chk_state("frz_load", 2'd1, 'h44);
    en = 1'b0; in_data = 'h99; #1;
    chk("frz_ready", W'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("frz_hold", 2'd1, 'h44);
    end
    en = 1'b1; step(); chk_state("frz_resume", 2'd1, 'h99);
    in_valid = 1'b0; step(); chk_state("frz_drain", 2'd0, '0);

`ifdef PIPE_SKID_EN
    // Backpressure fills the skid slot, third push refused.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 'h10; step(); chk_state("bp1", 2'd1, 'h10);
    in_data = 'h20; step(); chk_state("bp2", 2'd2, 'h10);
    chk("bp_ready", W'(in_ready), 0);
    in_data = 'h30; step(); chk_state("bp_refuse", 2'd2, 'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    step(); chk_state("pop1", 2'd1, 'h20);
    step(); chk_state("pop2", 2'd0, '0);

    // Flush while full, with a push offered the same cycle.
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 'h11; step(); in_data = 'h22; step();
    chk_state("fl_full", 2'd2, 'h11);
    flush = 1'b1; in_data = 'h55; out_ready = 1'b1; step();
    chk_state("fl_clear", 2'd0, '0);
    flush = 1'b0; in_valid = 1'b0; step();
    chk_state("fl_nostore", 2'd0, '0);
`else
    // Single slot: in_ready follows out_ready in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 'h7; step();
    chk_state("ns_hold7", 2'd1, 'h7);
    in_data = 'h8; #1;
    chk("ns_ready_lo", W'(in_ready), 0);
    step(); chk_state("ns_still7", 2'd1, 'h7);
    out_ready = 1'b1; #1;
    chk("ns_ready_hi", W'(in_ready), 1);
    step(); chk_state("ns_take8", 2'd1, 'h8);

    // Flush with accept+retire offered the same cycle.
    flush = 1'b1; in_data = 'h55; step();
    chk_state("fl_clear", 2'd0, '0);
    flush = 1'b0; in_valid = 1'b0; step();
    chk_state("fl_nostore", 2'd0, '0);
`endif

    // Flush acts even while frozen.
    in_valid = 1'b1; in_data = 'h3C; step();
    en = 1'b0; flush = 1'b1; step();
    chk_state("fl_frozen", 2'd0, '0);
    en = 1'b1; flush = 1'b0;

    // Asynchronous reset mid-transfer, then a clean restart.
    in_data = 'h5A; step(); chk_state("pre_rst", 2'd1, 'h5A);
    #2 nRST = 1'b0; #1;
    chk_state("async_rst", 2'd0, '0);
    in_data = 'h66; step();
    nRST = 1'b1; step();
    chk_state("post_rst", 2'd1, 'h66);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 128: payload width in bits (any stage bundle: data, control, instruction).
REQ-002 Parameter NOP_VAL, default all-zero: payload value presented on reset and after flush.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 nRST  input  1  asynchronous reset, active-low.
REQ-005 en  input  1  global advance enable (ihit/dhit qualified upstream); low freezes the stage.
REQ-006 flush  input  1  discard all held entries at next edge.
REQ-007 in_valid  input  1  upstream payload valid.
REQ-008 in_ready  output  1  stage accepts payload this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  out_data holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 out_data  output  DATA_W  head entry payload; NOP_VAL when empty.
REQ-013 occ  output  2  entries held (0..2).

Function
REQ-014 Accept = en && in_valid && in_ready; retire = en && out_valid && out_ready; both evaluated in the same cycle.
REQ-015 en low: no accept, no retire, all state/outputs held; in_ready and out_valid unaffected combinationally except in_ready forced low.
REQ-016 Payload latency in->out: exactly one edge when stage empty or retiring.
REQ-017 States EMPTY (occ 0), ONE (occ 1), TWO (occ 2, skid build only).
REQ-018 EMPTY: accept -> ONE, payload to head; else stay.
REQ-019 ONE: accept+retire -> ONE, head replaced; retire only -> EMPTY, head = NOP_VAL; accept only -> TWO (skid) with payload to skid slot.
REQ-020 TWO: retire -> ONE, skid slot moves to head; no accept possible (in_ready low).
REQ-021 Ordering strictly FIFO; no payload dropped or duplicated except by flush.
REQ-022 flush: next edge -> EMPTY, head = NOP_VAL, occ 0; flush overrides simultaneous accept/retire and acts regardless of en.
REQ-023 out_valid = (occ != 0); out_data never X after reset.

Reset
REQ-024 nRST low asynchronously forces EMPTY, out_valid 0, out_data NOP_VAL, occ 0, skid slot NOP_VAL.
REQ-025 Reset mid-transfer discards all entries; first accept after release behaves as from EMPTY.

Configuration
REQ-026 Macro PIPE_SKID_EN defined: two-entry skid buffer; in_ready = en && (occ != 2), registered-derived, no combinational path from out_ready.
REQ-027 PIPE_SKID_EN undefined: single entry, TWO unreachable, occ max 1; in_ready = en && (!out_valid || out_ready) (combinational pass-through).

Structure
REQ-028 State enum (EMPTY/ONE/TWO) typedef and default NOP_VAL width constant in cpu_types_pkg.
REQ-029 Single flat module; no sub-module; instantiable per stage (IF/ID, ID/EX, EX/MEM, MEM/WB) with DATA_W sized to the stage bundle.

Verification
REQ-030 Reset: nRST low with in_valid 1, in_data 0xA5..A5 -> occ 0, out_valid 0, out_data NOP_VAL.
REQ-031 Stream: en 1, out_ready 1, in_data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later each, occ stays 1.
REQ-032 Backpressure (skid): out_ready 0, push 0x10 then 0x20 -> occ 2, in_ready 0, push 0x30 refused; out_ready 1 -> pops 0x10, 0x20 in order.
REQ-033 Freeze: en 0 for 3 cycles with in_valid 1, out_ready 1 -> occ, out_data unchanged; en 1 resumes with no loss.
REQ-034 Flush collision: occ 2, flush 1 with accept of 0x55 same cycle -> next edge occ 0, out_data NOP_VAL, 0x55 not stored.
REQ-035 Non-skid build: out_ready 0 while holding 0x7 -> in_ready 0 same cycle; out_ready 1 with in_valid 1 (0x8) -> next edge out_data 0x8.
